sblk_act_feeder: RTL
====================

# sblk_act_feeder

Upstream activation feeder for the super-block controller. Accepts a one-cycle activation batch request, then pulls exactly one batch of activation words from a valid/ready source stream. It forwards each word as a registered valid-qualified write beat to the sblk activation buffer. One batch is `n_tn * n_tp * N_TILE` words, in tile-major order: tile 0 first, `n_tn*n_tp` words per tile.

## Interface
- `N_TILE`, 4, number of stiles per super-block
- `WID_ACT`, 8, activation width; one beat carries two activations
- `WID_INST_TN`, 3, width of the `n_tn` field
- `WID_INST_TP`, 2, width of the `n_tp` field
- `WID_BATCH`, `$clog2(N_TILE)+WID_INST_TN+WID_INST_TP`, beat-counter and batch-length width

Ports:
- `clk_l` in 1: clock
- `rst_n` in 1: reset, asynchronous, active-low
- `inst_data` in `WID_INST_TN+WID_INST_TP`: `n_tn` in bits `[0+:WID_INST_TN]`, `n_tp` in the bits above it
- `inst_en` in 1: load `inst_data` (same cycle as the sblk controller's `inst_en`)
- `act_in_req` in 1: one-cycle batch request from the sblk controller
- `act_in_vld` out 1: activation beat valid to the sblk
- `act_in` out `2*WID_ACT`: activation beat data
- `src_data` in `2*WID_ACT`: source stream data
- `src_vld` in 1: source valid
- `src_rdy` out 1: source ready
- `busy` out 1: batch in progress or pending
- `batch_done` out 1: one-cycle pulse, aligned with the last `act_in_vld` of a batch
- `err_req_ovf` out 1: sticky flag, a request was dropped

## Operation
- **Config path:**
  - `inst_en` registers `inst_data` into `cfg_reg`.
  - `inst_en_d` (`inst_en` delayed one cycle) recomputes `batch_len = n_tn*n_tp*N_TILE`.
  - `batch_len` is registered and `WID_BATCH` bits wide; no overflow at maximum field values.
- **FSM states:** IDLE, STREAM.
- **IDLE:**
  - `src_rdy = 0`.
  - If `act_in_req` is high and `batch_len != 0`: go to STREAM and clear `beat_cnt`.
  - If `act_in_req` is high and `batch_len == 0`: the request is ignored. No beats, no `batch_done`, no error.
- **STREAM:**
  - `src_rdy = 1`, decoded combinationally from the state register.
  - Each handshake (`src_vld & src_rdy`) increments `beat_cnt` and launches one output beat.
  - On the handshake with `beat_cnt == batch_len-1`: return to IDLE and clear `beat_cnt`.
- **Output beat:** `act_in <= src_data` and `act_in_vld <= 1` on a handshake. Otherwise `act_in_vld <= 0` and `act_in` holds its value.
- **`batch_done`:** registered; high the cycle after the final handshake.
- **`busy`:** high in STREAM, or while a request is pending (queued requests only exist when `SBLK_FEED_REQ_QUEUE_EN` is defined; see Configuration).
- **`act_in_req` while in STREAM (no pending slot):** request dropped; `err_req_ovf <= 1`. The flag clears only on reset or `inst_en`.
- **`inst_en` in any state (abort):**
  - FSM goes to IDLE; `beat_cnt` and the pending slot are cleared.
  - `err_req_ovf` is cleared; no `batch_done` is generated.
  - A beat handshaken in the same cycle is still output the next cycle.
- **Reset values:** all outputs 0; `cfg_reg`, `batch_len`, `beat_cnt` are 0; FSM in IDLE.

## Timing
- **Config latency:** `inst_en` at edge t, `cfg_reg` valid after t, `batch_len` valid after t+1. A request must arrive no earlier than edge t+2; an earlier request sees the old `batch_len`.
- **Request to ready:** `act_in_req` sampled at edge r gives `src_rdy = 1` during cycle r+1.
- **Beat latency:** handshake at edge h gives `act_in_vld`/`act_in` during cycle h+1. Exactly 1 cycle, no skid.
- **Throughput:** 1 beat/cycle while `src_vld` is held high. Source stalls produce `act_in_vld` bubbles; order is preserved.
- **End of batch:** last handshake at edge e gives `src_rdy = 0` in cycle e+1 (unless a pending request restarts STREAM). `batch_done` and the last `act_in_vld` are both high in cycle e+1.
- **Request on the final-handshake edge:** treated as arriving in STREAM; dropped or queued.

## Configuration
- Macro: `SBLK_FEED_REQ_QUEUE_EN`.
- **Defined:**
  - One pending-request slot. A request arriving in STREAM sets `pending` instead of raising the error.
  - On the final handshake with `pending` set: stay in STREAM, clear `beat_cnt` and `pending`. `src_rdy` remains high with zero bubble cycles.
  - A request arriving while `pending` is already set is dropped and sets `err_req_ovf`.
- **Undefined:** no pending slot; any request arriving in STREAM is dropped and sets `err_req_ovf`.

## Test plan
- **Reset:** assert `rst_n = 0` mid-stream with `src_vld = 1` -> all outputs 0 immediately; after release, `src_rdy = 0` until a request arrives.
- **Basic batch:** `N_TILE = 4`, `n_tn = 2`, `n_tp = 1`, `inst_en`, request 2 cycles later, `src_vld` always high, data 0..7 -> `act_in` 0..7 on 8 consecutive `act_in_vld` cycles. `batch_done` aligned with data 7; `src_rdy` low afterwards; `busy` falls with `batch_done`.
- **Back-pressure:** same config, `src_vld` toggling 1,0,1,0 -> 8 beats with one-cycle gaps, data order intact, `batch_done` on the 8th beat.
- **Zero length:** `n_tp = 0`, then `act_in_req` -> no `src_rdy`, no `act_in_vld`, no `batch_done`, `err_req_ovf = 0`.
- **Overlapping requests:** with the macro defined, second request mid-batch -> 16 beats with `src_rdy` continuous, two `batch_done` pulses, `err_req_ovf = 0`. A third request while `pending` is set -> `err_req_ovf = 1`. Without the macro, the second request -> `err_req_ovf = 1` and only 8 beats.
- **Abort:** `n_tn = 7`, `n_tp = 3`, `N_TILE = 4` (batch of 84). Issue `inst_en` after 10 beats -> FSM back to IDLE, no `batch_done`, `err_req_ovf` cleared. A new request 2 cycles later streams a full new batch.

Source files
------------

// File: rtl/sblk_act_feeder_if.sv
// Signal bundle between the sblk controller/source side and sblk_act_feeder.
// The feeder binds to the slave modport. The controller/testbench side binds to the master modport.
interface sblk_act_feeder_if #(
  parameter int WID_ACT     = 8,
  parameter int WID_INST_TN = 3,
  parameter int WID_INST_TP = 2
);
  logic [WID_INST_TN+WID_INST_TP-1:0] inst_data;
  logic                               inst_en;
  logic                               act_in_req;
  logic                               act_in_vld;
  logic [2*WID_ACT-1:0]               act_in;
  logic [2*WID_ACT-1:0]               src_data;
  logic                               src_vld;
  logic                               src_rdy;
  logic                               busy;
  logic                               batch_done;
  logic                               err_req_ovf;
  logic                               dbg_state;

  modport slave (
    input  inst_data, inst_en, act_in_req, src_data, src_vld,
    output act_in_vld, act_in, src_rdy, busy, batch_done, err_req_ovf, dbg_state
  );

  modport master (
    output inst_data, inst_en, act_in_req, src_data, src_vld,
    input  act_in_vld, act_in, src_rdy, busy, batch_done, err_req_ovf, dbg_state
  );
endinterface

// File: rtl/sblk_act_feeder.sv
// Pulls one batch (n_tn*n_tp*N_TILE words) from a valid/ready source and forwards it as registered beats.
// Optional single pending-request slot is enabled by defining SBLK_FEED_REQ_QUEUE_EN.
module sblk_act_feeder #(
  parameter int N_TILE      = 4,
  parameter int WID_ACT     = 8,
  parameter int WID_INST_TN = 3,
  parameter int WID_INST_TP = 2,
  parameter int WID_BATCH   = $clog2(N_TILE) + WID_INST_TN + WID_INST_TP
) (
  input logic               clk_l,
  input logic               rst_n,
  sblk_act_feeder_if.slave  bus
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  localparam logic [WID_BATCH-1:0] BATCH_ONE = WID_BATCH'(1);

  state_t                             state_q, state_d;
  logic [WID_INST_TN+WID_INST_TP-1:0] cfg_reg;
  logic                               inst_en_d;
  logic [WID_INST_TN-1:0]             n_tn;
  logic [WID_INST_TP-1:0]             n_tp;
  logic [WID_BATCH-1:0]               len_calc;
  logic [WID_BATCH-1:0]               batch_len;
  logic [WID_BATCH-1:0]               beat_cnt_q, beat_cnt_d;
  logic                               err_q, err_d;
  logic                               done_q, done_d;
  logic                               vld_q;
  logic [2*WID_ACT-1:0]               act_q;
  logic                               pending_q;
  logic                               hs;
  logic                               last_beat;

  // Config path: fields latch on inst_en; the product is formed one cycle later.
  assign n_tn     = cfg_reg[0 +: WID_INST_TN];
  assign n_tp     = cfg_reg[WID_INST_TN +: WID_INST_TP];
  assign len_calc = WID_BATCH'(n_tn) * WID_BATCH'(n_tp) * WID_BATCH'(N_TILE);

  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      cfg_reg   <= '0;
      inst_en_d <= 1'b0;
      batch_len <= '0;
    end else begin
      inst_en_d <= bus.inst_en;
      if (bus.inst_en) cfg_reg <= bus.inst_data;
      if (inst_en_d) batch_len <= len_calc;
    end
  end

  // A source word transfers on any rising clk_l edge where src_vld and src_rdy
  // are both high. src_rdy never depends on src_vld, and once a word is offered
  // the source holds it until the transfer edge.
  assign bus.src_rdy = (state_q == S_STREAM);
  assign hs          = bus.src_vld & bus.src_rdy;
  assign last_beat   = hs && (beat_cnt_q == batch_len - BATCH_ONE);

`ifdef SBLK_FEED_REQ_QUEUE_EN
  logic pending_d;
`endif

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    done_d     = 1'b0;
`ifdef SBLK_FEED_REQ_QUEUE_EN
    pending_d  = pending_q;
`endif
    if (bus.inst_en) begin
      state_d    = S_IDLE;
      beat_cnt_d = '0;
      err_d      = 1'b0;
`ifdef SBLK_FEED_REQ_QUEUE_EN
      pending_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.act_in_req && (batch_len != '0)) begin
            state_d    = S_STREAM;
            beat_cnt_d = '0;
          end
        end
        S_STREAM: begin
          if (hs) begin
            beat_cnt_d = beat_cnt_q + BATCH_ONE;
            if (last_beat) begin
              done_d     = 1'b1;
              beat_cnt_d = '0;
              state_d    = S_IDLE;
            end
          end
`ifdef SBLK_FEED_REQ_QUEUE_EN
          // A queued request restarts the next batch on the final edge, no bubble.
          if (last_beat && pending_q) begin
            state_d   = S_STREAM;
            pending_d = 1'b0;
          end
          if (bus.act_in_req) begin
            if (pending_q)      err_d     = 1'b1;
            else if (last_beat) state_d   = S_STREAM;
            else                pending_d = 1'b1;
          end
`else
          if (bus.act_in_req) err_d = 1'b1;
`endif
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

`ifdef SBLK_FEED_REQ_QUEUE_EN
  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) pending_q <= 1'b0;
    else        pending_q <= pending_d;
  end
`else
  assign pending_q = 1'b0;
`endif

  // Output beat: a word accepted on an abort edge is still forwarded.
  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      act_q <= '0;
    end else begin
      vld_q <= hs;
      if (hs) act_q <= bus.src_data;
    end
  end

  assign bus.act_in_vld  = vld_q;
  assign bus.act_in      = act_q;
  assign bus.batch_done  = done_q;
  assign bus.err_req_ovf = err_q;
  assign bus.busy        = (state_q == S_STREAM) | pending_q;
  assign bus.dbg_state   = state_q;

endmodule
